// File: rtl/frame_ctrl_pkg.sv
// Shared types and default geometry for the AXI4-Stream frame sequencer.
package frame_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  localparam int unsigned HActiveDefault = 640;
  localparam int unsigned VActiveDefault = 480;

endpackage

// File: rtl/sw_debounce.sv
// Synchronizes an asynchronous switch and changes the output only after it
// has held its new level for DebCycles consecutive clocks.
module sw_debounce #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DebCycles  = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic sw_o
);

  localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sw_sync;
  logic                  sw_q, sw_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign sw_sync = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      sw_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], sw_i};
      sw_q   <= sw_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any cycle where the synced level agrees with the output restarts the count.
  always_comb begin
    sw_d  = sw_q;
    cnt_d = '0;
    if (sw_sync != sw_q) begin
      if (cnt_q == CntMax) begin
        sw_d  = sw_sync;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign sw_o = sw_q;

endmodule

// File: rtl/axis_frame_mode_ctrl.sv
// Frame-level sequencer for the unsharp-filter path: tracks beat position,
// flags line/frame boundaries, latches the filter mode at start of frame.
module axis_frame_mode_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = HActiveDefault,
  parameter int unsigned V_ACTIVE    = VActiveDefault,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 1_000_000
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        sw_0,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tready,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  input  logic                        clr_err,
  output logic                        filter_en,
  output logic                        col_first,
  output logic                        col_last,
  output logic                        row_first,
  output logic                        row_last,
  output logic [$clog2(H_ACTIVE)-1:0] x_cnt,
  output logic [$clog2(V_ACTIVE)-1:0] y_cnt,
  output logic                        frame_done,
  output logic                        err_short_line,
  output logic                        err_long_line,
  output logic                        err_frame,
  output logic                        in_frame
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            filter_en_q, filter_en_d;
  logic            done_q, done_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            frame_err_q, frame_err_d;
  logic            resync_q, resync_d;
  logic            set_short, set_long, set_frame;
  logic            beat;
  logic            sw_deb;

  sw_debounce #(
    .SyncStages (SYNC_STAGES),
    .DebCycles  (DEB_CYCLES)
  ) u_sw_debounce (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .sw_i   (sw_0),
    .sw_o   (sw_deb)
  );

  assign beat = s_axis_tvalid && s_axis_tready;

  // State register. resync_q marks "came out of reset, stream position unknown".
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      filter_en_q <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      frame_err_q <= 1'b0;
      resync_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      filter_en_q <= filter_en_d;
      done_q      <= done_d;
      short_q     <= short_d;
      long_q      <= long_d;
      frame_err_q <= frame_err_d;
      resync_q    <= resync_d;
    end
  end

  // Next-state logic: position tracking and error event detection.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    filter_en_d = filter_en_q;
    done_d      = 1'b0;
    resync_d    = resync_q;
    set_short   = 1'b0;
    set_long    = 1'b0;
    set_frame   = 1'b0;

    if (beat) begin
      if (s_axis_tuser) begin
        // A tuser beat is column 0 of row 0; the next beat is column 1.
        state_d     = StActive;
        x_d         = XW'(1);
        y_d         = '0;
        filter_en_d = sw_deb;
        resync_d    = 1'b0;
        set_frame   = (state_q == StActive);
      end else begin
        case (state_q)
          StIdle: begin
            set_frame = !resync_q;
          end
          StActive: begin
            if (s_axis_tlast) begin
              set_short = (x_q != XLast);
              x_d       = '0;
              if (y_q == YLast) begin
                y_d     = '0;
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                y_d     = y_q + YW'(1);
              end
            end else if (x_q == XLast) begin
              set_long = 1'b1;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end

    // A new error event outranks a simultaneous clear.
    short_d     = set_short | (short_q     & ~clr_err);
    long_d      = set_long  | (long_q      & ~clr_err);
    frame_err_d = set_frame | (frame_err_q & ~clr_err);
  end

  // Outputs. Boundary flags only describe a position while inside a frame.
  always_comb begin
    in_frame       = (state_q == StActive);
    col_first      = in_frame && (x_q == '0);
    col_last       = in_frame && (x_q == XLast);
    row_first      = in_frame && (y_q == '0);
    row_last       = in_frame && (y_q == YLast);
    x_cnt          = x_q;
    y_cnt          = y_q;
    filter_en      = filter_en_q;
    frame_done     = done_q;
    err_short_line = short_q;
    err_long_line  = long_q;
    err_frame      = frame_err_q;
  end

endmodule

// File: tb/tb_axis_frame_mode_ctrl.sv
// Directed bench for axis_frame_mode_ctrl with an 8x4 frame geometry.
module tb_axis_frame_mode_ctrl;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       sw_0 = 1'b0;
  logic       tvalid = 1'b0, tready = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic       clr_err = 1'b0;
  logic       filter_en, col_first, col_last, row_first, row_last;
  logic [2:0] x_cnt;
  logic [1:0] y_cnt;
  logic       frame_done, err_short_line, err_long_line, err_frame, in_frame;

  int n_checks = 0;
  int n_errors = 0;

  // Boundary flags sampled mid-beat by send().
  logic s_cf, s_cl, s_rf, s_rl;

  always #5 aclk = ~aclk;

  axis_frame_mode_ctrl #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .sw_0           (sw_0),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tuser   (tuser),
    .s_axis_tlast   (tlast),
    .clr_err        (clr_err),
    .filter_en      (filter_en),
    .col_first      (col_first),
    .col_last       (col_last),
    .row_first      (row_first),
    .row_last       (row_last),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt),
    .frame_done     (frame_done),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_frame      (err_frame),
    .in_frame       (in_frame)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {filter_en, col_first, col_last, row_first, row_last, frame_done,
            err_short_line, err_long_line, err_frame, in_frame, x_cnt, y_cnt};
  endfunction

  function automatic logic [2:0] errs();
    return {err_short_line, err_long_line, err_frame};
  endfunction

  // Entered and left at posedge+1. Up to gmax non-beat cycles precede the beat.
  task automatic send(input logic u, input logic l, input int unsigned gmax);
    int unsigned g;
    g = (gmax == 0) ? 0 : $urandom_range(gmax, 0);
    repeat (g) begin
      tvalid = 1'($urandom_range(1, 0));
      tready = ~tvalid;
      tuser  = 1'($urandom_range(1, 0));
      tlast  = 1'($urandom_range(1, 0));
      @(posedge aclk); #1;
    end
    tvalid = 1'b1; tready = 1'b1; tuser = u; tlast = l;
    @(negedge aclk);
    s_cf = col_first; s_cl = col_last; s_rf = row_first; s_rl = row_last;
    @(posedge aclk); #1;
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Beats k = from..to of a well-formed frame.
  task automatic beats(input int from, input int to, input int unsigned gmax);
    for (int k = from; k <= to; k++) send(k == 0, (k % H) == H - 1, gmax);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge aclk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #7;
    check_eq("reset_outputs", all_outs(), 15'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("post_reset_outputs", all_outs(), 15'h0);

    // Clean frame with random non-beat gaps.
    for (int i = 0; i < 32; i++) begin
      send(i == 0, (i % 8) == 7, 2);
      check_eq("clean_col_first", s_cf, (i != 0) && (i % 8 == 0));
      check_eq("clean_col_last", s_cl, (i % 8) == 7);
      check_eq("clean_row_first", s_rf, (i != 0) && (i < 8));
      check_eq("clean_row_last", s_rl, i >= 24);
      check_eq("clean_frame_done", frame_done, i == 31);
    end
    check_eq("clean_idle", in_frame, 1'b0);
    check_eq("clean_errs", errs(), 3'b000);
    idle(1);
    check_eq("clean_done_one_cycle", frame_done, 1'b0);

    // Mode latch: switch rises mid-frame, applies only from the next tuser.
    beats(0, 3, 0);
    sw_0 = 1'b1;
    idle(10);
    check_eq("mode_hold_mid", filter_en, 1'b0);
    beats(4, 31, 0);
    check_eq("mode_hold_end", filter_en, 1'b0);
    beats(0, 0, 0);
    check_eq("mode_latched", filter_en, 1'b1);
    sw_0 = 1'b0;
    idle(3);
    sw_0 = 1'b1;
    idle(10);
    beats(1, 31, 0);
    beats(0, 0, 0);
    check_eq("glitch_ignored", filter_en, 1'b1);
    beats(1, 31, 0);
    check_eq("mode_frame_done", frame_done, 1'b1);

    // Short line on row 1: tlast at x=5.
    beats(0, 7, 1);
    for (int x = 0; x < 6; x++) send(1'b0, x == 5, 1);
    check_eq("short_errs", errs(), 3'b100);
    check_eq("short_x", x_cnt, 3'd0);
    check_eq("short_y", y_cnt, 2'd2);
    beats(16, 31, 1);
    check_eq("short_frame_done", frame_done, 1'b1);
    pulse_clr();
    check_eq("short_cleared", errs(), 3'b000);

    // Long line: 10 beats on row 0, then tlast.
    send(1'b1, 1'b0, 1);
    for (int k = 1; k < 10; k++) begin
      send(1'b0, 1'b0, 1);
      if (k >= 7) check_eq("long_col_last", s_cl, 1'b1);
    end
    check_eq("long_errs", errs(), 3'b010);
    check_eq("long_x_sat", x_cnt, 3'd7);
    check_eq("long_y", y_cnt, 2'd0);
    send(1'b0, 1'b1, 1);
    check_eq("long_tlast_x", x_cnt, 3'd0);
    check_eq("long_tlast_y", y_cnt, 2'd1);
    beats(8, 31, 1);
    check_eq("long_frame_done", frame_done, 1'b1);
    pulse_clr();
    check_eq("long_cleared", errs(), 3'b000);

    // Early tuser at row 2, x=3.
    beats(0, 18, 0);
    check_eq("early_pre_x", x_cnt, 3'd3);
    check_eq("early_pre_y", y_cnt, 2'd2);
    send(1'b1, 1'b0, 0);
    check_eq("early_errs", errs(), 3'b001);
    check_eq("early_x", x_cnt, 3'd1);
    check_eq("early_y", y_cnt, 2'd0);
    check_eq("early_relatch", filter_en, 1'b1);
    pulse_clr();
    check_eq("early_cleared", errs(), 3'b000);
    clr_err = 1'b1;
    send(1'b1, 1'b0, 0);
    clr_err = 1'b0;
    check_eq("clr_vs_err", errs(), 3'b001);
    pulse_clr();
    check_eq("clr_again", errs(), 3'b000);

    // Reset mid-frame at row 2.
    beats(1, 17, 0);
    check_eq("rst_pre_y", y_cnt, 2'd2);
    check_eq("rst_pre_in_frame", in_frame, 1'b1);
    #2 aresetn = 1'b0;
    #1 check_eq("rst_async_outputs", all_outs(), 15'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int k = 0; k < 5; k++) send(1'b0, k == 3, 0);
    check_eq("rst_ignored_outputs", all_outs(), 15'h0);
    idle(10);
    send(1'b1, 1'b0, 0);
    check_eq("rst_new_in_frame", in_frame, 1'b1);
    check_eq("rst_new_x", x_cnt, 3'd1);
    check_eq("rst_new_filter_en", filter_en, 1'b1);
    beats(1, 31, 0);
    check_eq("rst_new_done", frame_done, 1'b1);
    check_eq("rst_new_errs", errs(), 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_mode_ctrl.md
# axis_frame_mode_ctrl

Frame-level sequencer for the AXI4-Stream unsharp-filter path. Snoops the filter's input handshake, tracks pixel/line position, and flags line and frame boundaries so the filter can suppress blur across line edges. Debounces the raw filter switch and applies the new mode only at start of frame, so a frame is never half-sharpened. Reports malformed frames through sticky error flags. Sits beside the filter and drives its enable and boundary inputs.

## Interface
Parameters:
- H_ACTIVE, 640: pixels per line
- V_ACTIVE, 480: lines per frame
- SYNC_STAGES, 2: switch synchronizer depth (≥2)
- DEB_CYCLES, 1_000_000: stable cycles required before the debounced switch changes

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- sw_0  in  1  raw filter-enable switch, asynchronous
- s_axis_tvalid  in  1  snooped filter input valid
- s_axis_tready  in  1  snooped filter input ready
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- clr_err  in  1  one-cycle pulse, clears sticky errors
- filter_en  out  1  frame-latched filter mode
- col_first / col_last  out  1  next beat is column 0 / H_ACTIVE-1
- row_first / row_last  out  1  next beat is in row 0 / V_ACTIVE-1
- x_cnt  out  $clog2(H_ACTIVE)  column of next beat
- y_cnt  out  $clog2(V_ACTIVE)  row of next beat
- frame_done  out  1  one-cycle pulse after the final beat of a frame
- err_short_line, err_long_line, err_frame  out  1  sticky error flags
- in_frame  out  1  state is ACTIVE

## Operation
- Beat = s_axis_tvalid && s_axis_tready. Non-beat cycles change nothing except the debouncer.
- Switch path: SYNC_STAGES flop synchronizer feeds a counter. When the synced value differs from sw_deb, the counter counts; when it reaches DEB_CYCLES-1, sw_deb takes the new value. Any return to the sw_deb value clears the counter.
- FSM states:
  - IDLE: x=y=0. A beat with tuser latches filter_en←sw_deb, counts the beat, and enters ACTIVE. A beat without tuser is ignored and sets err_frame.
  - ACTIVE, beat with tuser: the frame restarts at this beat (x=1, y=0, filter_en relatched) and sets err_frame.
  - ACTIVE, beat with tlast and x<H_ACTIVE-1: sets err_short_line, then x←0, y++.
  - ACTIVE, beat at x=H_ACTIVE-1 without tlast: sets err_long_line; x stays saturated at H_ACTIVE-1 until the tlast beat.
  - ACTIVE, tlast beat at y=V_ACTIVE-1: frame_done is asserted next cycle, x=y=0, FSM returns to IDLE.
  - ACTIVE, otherwise: tlast gives x←0, y++; no tlast gives x++.
- Boundary flags are combinational from x_cnt/y_cnt, so they are valid in the same cycle as the beat they describe.
- Errors are sticky until clr_err. If clr_err and a new error event occur in the same cycle, the error wins.
- filter_en never changes except on a tuser beat.

## Timing
- Reset values: all outputs 0. filter_en=0, state IDLE, sw_deb=0, debounce counter 0.
- Reset asserted mid-frame: state returns to IDLE immediately and asynchronously. The remainder of that frame is ignored until the next tuser; no error is flagged for the beats ignored after reset.
- Counters, state and flags update on the rising aclk edge of the beat.
- frame_done: exactly 1 cycle, on the cycle after the final beat.
- Switch latency: SYNC_STAGES + DEB_CYCLES cycles from a stable edge to sw_deb. The switch then affects output only from the next tuser beat.
- No backpressure is generated; the block is a pure observer plus control.

## Structure
- Shared package frame_ctrl_pkg: state enum (IDLE, ACTIVE), default H_ACTIVE/V_ACTIVE constants.
- Sub-module sw_debounce (synchronizer + stable counter), instantiated once.
- The FSM and counters stay in the top level.

## Test plan
Benches use H_ACTIVE=8, V_ACTIVE=4, SYNC_STAGES=2, DEB_CYCLES=4.
- Clean frame: 32 beats with tuser on beat 0 and tlast every 8th, random tvalid gaps → frame_done pulses once, 1 cycle after beat 31. col_last is high on beats 7, 15, 23, 31. No errors. FSM ends in IDLE.
- Mode latch: sw_0 raised mid-frame, held >6 cycles → filter_en stays 0 until the next tuser beat, then 1. A 3-cycle glitch on sw_0 → sw_deb is unchanged.
- Short line: tlast at x=5 on row 1 → err_short_line=1, next beat has x_cnt=0, y_cnt=2.
- Long line: 10 beats on row 0 before tlast → err_long_line=1, x_cnt holds 7, tlast returns x_cnt to 0 with y_cnt=1.
- Early tuser: tuser at row 2, x=3 → err_frame=1, x_cnt=1, y_cnt=0. clr_err pulse then clears all flags.
- Reset mid-frame: aresetn low at row 2 → all outputs 0 immediately. Beats without tuser after release are ignored; the next tuser starts a clean frame.
